// File: rtl/punc_mem_arbiter.sv
// punc_mem_arbiter: shares PUnC's single-port data memory between the CPU
// datapath (port 0) and the debug/program-loader port (port 1). Grants are
// decided combinationally within the cycle, a lock lets one port keep the
// memory for back-to-back accesses, a wait counter keeps the low-priority
// port from starving, and a tag pipeline routes read data to its issuer.
module punc_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int READ_LAT  = 1,
  parameter int PRIO_PORT = 0,
  parameter int MAX_WAIT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  owner_e              owner_q;
  logic [7:0]          wait_q;
  logic [7:0]          wait_d;
  logic [READ_LAT-1:0] tagVld_q;
  logic [READ_LAT-1:0] tagPort_q;
  logic                pushVld_d;
  logic                pushPort_d;
  logic                forceLow;
  logic                reqLow;
  logic                gntLow;

  // The low-priority port is the one that is not PRIO_PORT; it is the only
  // one whose refusals are counted.
  assign reqLow   = (PRIO_PORT == 0) ? req1 : req0;
  assign gntLow   = (PRIO_PORT == 0) ? gnt1 : gnt0;
  assign forceLow = (wait_q == MaxWait);

  // Per-cycle grant selection; a held lock shuts the other port out
  // completely, and nothing is granted while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      case (owner_q)
        FREE: begin
          if (req0 && req1) begin
            if ((PRIO_PORT == 0) != forceLow) gnt0 = 1'b1;
            else                              gnt1 = 1'b1;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        OWN0:    gnt0 = req0;
        OWN1:    gnt1 = req1;
        default: ;
      endcase
    end
  end

  // Memory bus mux: the granted port drives the bus, otherwise it is all zero.
  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Next wait count and the tag that a granted read pushes into the pipeline.
  always_comb begin
    wait_d = 8'd0;
    if (reqLow && !gntLow) begin
      wait_d = forceLow ? wait_q : wait_q + 8'd1;
    end
    pushVld_d  = (gnt0 && !we0) || (gnt1 && !we1);
    pushPort_d = gnt1;
  end

  // Owner FSM: a locked grant takes ownership, dropping the lock releases it
  // whether or not a final access is made in that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= FREE;
    end else begin
      case (owner_q)
        FREE: begin
          if (gnt0 && lock0)      owner_q <= OWN0;
          else if (gnt1 && lock1) owner_q <= OWN1;
        end
        OWN0:    if (!lock0) owner_q <= FREE;
        OWN1:    if (!lock1) owner_q <= FREE;
        default: owner_q <= FREE;
      endcase
    end
  end

  // Starvation counter for the low-priority port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_q <= 8'd0;
    else      wait_q <= wait_d;
  end

  // Read-tag shift register; reset drops every in-flight tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tagVld_q  <= '0;
      tagPort_q <= '0;
    end else begin
      for (int i = READ_LAT - 1; i > 0; i--) begin
        tagVld_q[i]  <= tagVld_q[i-1];
        tagPort_q[i] <= tagPort_q[i-1];
      end
      tagVld_q[0]  <= pushVld_d;
      tagPort_q[0] <= pushPort_d;
    end
  end

  assign rvalid0 = tagVld_q[READ_LAT-1] & ~tagPort_q[READ_LAT-1];
  assign rvalid1 = tagVld_q[READ_LAT-1] &  tagPort_q[READ_LAT-1];
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// tb_punc_mem_arbiter: three arbiters with READ_LAT 1, 2 and 3 share one
// stimulus stream; a small memory model serves each with its own latency.
module tb_punc_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [15:0] addr0, wdata0, addr1, wdata1;

  logic        gnt0A, gnt1A, rvalid0A, rvalid1A, memEnA, memWeA;
  logic [15:0] rdata0A, rdata1A, memAddrA, memWdataA, memRdA;
  logic        gnt0B, gnt1B, rvalid0B, rvalid1B, memEnB, memWeB;
  logic [15:0] rdata0B, rdata1B, memAddrB, memWdataB, memRdB;
  logic        gnt0C, gnt1C, rvalid0C, rvalid1C, memEnC, memWeC;
  logic [15:0] rdata0C, rdata1C, memAddrC, memWdataC, memRdC;

  logic [15:0] mem   [0:255];
  logic [15:0] ahist [0:3];

  int passCnt  = 0;
  int totalCnt = 0;

  typedef struct {
    logic        r0, w0, l0;
    logic [15:0] a0, d0;
    logic        r1, w1, l1;
    logic [15:0] a1, d1;
    logic        eg0, eg1, een, ewe;
    logic [15:0] eaddr, ewdata;
    logic        ev0, ev1;
    logic [15:0] erd;
  } vec_t;

  vec_t vecs [12];

  punc_mem_arbiter #(.READ_LAT(1)) dutA (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0A), .rvalid0(rvalid0A), .rdata0(rdata0A),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1A), .rvalid1(rvalid1A), .rdata1(rdata1A),
    .mem_en(memEnA), .mem_we(memWeA), .mem_addr(memAddrA),
    .mem_wdata(memWdataA), .mem_rdata(memRdA)
  );

  punc_mem_arbiter #(.READ_LAT(2)) dutB (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0B), .rvalid0(rvalid0B), .rdata0(rdata0B),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1B), .rvalid1(rvalid1B), .rdata1(rdata1B),
    .mem_en(memEnB), .mem_we(memWeB), .mem_addr(memAddrB),
    .mem_wdata(memWdataB), .mem_rdata(memRdB)
  );

  punc_mem_arbiter #(.READ_LAT(3)) dutC (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0C), .rvalid0(rvalid0C), .rdata0(rdata0C),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1C), .rvalid1(rvalid1C), .rdata1(rdata1C),
    .mem_en(memEnC), .mem_we(memWeC), .mem_addr(memAddrC),
    .mem_wdata(memWdataC), .mem_rdata(memRdC)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: preloaded on reset, written from dutA's bus (all three
  // arbiters see the same requests, so their grants coincide), and an address
  // history that gives each arbiter its own read latency.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
      mem[16] <= 16'hBEEF;
    end else if (memEnA && memWeA) begin
      mem[memAddrA[7:0]] <= memWdataA;
    end
    ahist[0] <= memAddrA;
    for (int i = 1; i < 4; i++) ahist[i] <= ahist[i-1];
  end

  assign memRdA = mem[ahist[0][7:0]];
  assign memRdB = mem[ahist[1][7:0]];
  assign memRdC = mem[ahist[2][7:0]];

  // Compare one value and count the result.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one cycle of requests after the falling edge and let it settle.
  task automatic applyStimulus(input logic r0, input logic w0, input logic l0,
                               input logic [15:0] a0, input logic [15:0] d0,
                               input logic r1, input logic w1, input logic l1,
                               input logic [15:0] a1, input logic [15:0] d1);
    @(negedge clk);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  // Main sequence: reset, vector table, then multi-cycle corner cases.
  initial begin
    rst = 1'b0;
    req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;

    vecs[0]  = '{0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000, 0,0,16'h0000};
    vecs[1]  = '{1,0,0,16'h0010,16'h0000, 0,0,0,16'h0000,16'h0000, 1,0,1,0,16'h0010,16'h0000, 0,0,16'h0000};
    vecs[2]  = '{0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000, 1,0,16'hBEEF};
    vecs[3]  = '{0,0,0,16'h0000,16'h0000, 1,1,0,16'h0020,16'h1234, 0,1,1,1,16'h0020,16'h1234, 0,0,16'h0000};
    vecs[4]  = '{0,0,0,16'h0000,16'h0000, 1,0,0,16'h0020,16'h0000, 0,1,1,0,16'h0020,16'h0000, 0,0,16'h0000};
    vecs[5]  = '{0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000, 0,1,16'h1234};
    vecs[6]  = '{1,1,0,16'h0005,16'hAAAA, 1,0,0,16'h0003,16'h0000, 1,0,1,1,16'h0005,16'hAAAA, 0,0,16'h0000};
    vecs[7]  = '{0,0,0,16'h0000,16'h0000, 1,0,0,16'h0003,16'h0000, 0,1,1,0,16'h0003,16'h0000, 0,0,16'h0000};
    vecs[8]  = '{0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000, 0,1,16'h1003};
    vecs[9]  = '{1,0,0,16'h0005,16'h0000, 0,0,0,16'h0000,16'h0000, 1,0,1,0,16'h0005,16'h0000, 0,0,16'h0000};
    vecs[10] = '{0,0,0,16'h0000,16'h0000, 1,0,0,16'h0010,16'h0000, 0,1,1,0,16'h0010,16'h0000, 1,0,16'hAAAA};
    vecs[11] = '{0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000, 0,1,16'hBEEF};

    // Reset held with a request pending: nothing may be granted.
    @(negedge clk);
    @(negedge clk);
    req0 = 1; addr0 = 16'h0010;
    #1;
    checkOutput("rst.gnt0",    32'(gnt0A),    32'd0);
    checkOutput("rst.mem_en",  32'(memEnA),   32'd0);
    checkOutput("rst.mem_we",  32'(memWeA),   32'd0);
    checkOutput("rst.rvalid0", 32'(rvalid0A), 32'd0);
    checkOutput("rst.rvalid1", 32'(rvalid1A), 32'd0);
    @(negedge clk);
    rst = 1'b1; req0 = 0; addr0 = '0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].r0, vecs[i].w0, vecs[i].l0, vecs[i].a0, vecs[i].d0,
                    vecs[i].r1, vecs[i].w1, vecs[i].l1, vecs[i].a1, vecs[i].d1);
      checkOutput($sformatf("v%0d.gnt0", i),      32'(gnt0A),     32'(vecs[i].eg0));
      checkOutput($sformatf("v%0d.gnt1", i),      32'(gnt1A),     32'(vecs[i].eg1));
      checkOutput($sformatf("v%0d.mem_en", i),    32'(memEnA),    32'(vecs[i].een));
      checkOutput($sformatf("v%0d.mem_we", i),    32'(memWeA),    32'(vecs[i].ewe));
      checkOutput($sformatf("v%0d.mem_addr", i),  32'(memAddrA),  32'(vecs[i].eaddr));
      checkOutput($sformatf("v%0d.mem_wdata", i), 32'(memWdataA), 32'(vecs[i].ewdata));
      checkOutput($sformatf("v%0d.rvalid0", i),   32'(rvalid0A),  32'(vecs[i].ev0));
      checkOutput($sformatf("v%0d.rvalid1", i),   32'(rvalid1A),  32'(vecs[i].ev1));
      if (vecs[i].ev0) checkOutput($sformatf("v%0d.rdata0", i), 32'(rdata0A), 32'(vecs[i].erd));
      if (vecs[i].ev1) checkOutput($sformatf("v%0d.rdata1", i), 32'(rdata1A), 32'(vecs[i].erd));
    end

    // Both ports read every cycle: port 1 is forced through every 9th cycle.
    for (int c = 0; c < 18; c++) begin
      applyStimulus(1, 0, 0, 16'h0001, 16'h0, 1, 0, 0, 16'h0002, 16'h0);
      checkOutput($sformatf("starve%0d.gnt0", c), 32'(gnt0A), 32'((c % 9) != 8));
      checkOutput($sformatf("starve%0d.gnt1", c), 32'(gnt1A), 32'((c % 9) == 8));
    end
    idle();

    // Port 0 locks; port 1's write waits even after its counter saturates.
    applyStimulus(1, 0, 1, 16'h0010, 16'h0, 1, 1, 0, 16'h0020, 16'h1234);
    checkOutput("lock.first.gnt0", 32'(gnt0A), 32'd1);
    checkOutput("lock.first.gnt1", 32'(gnt1A), 32'd0);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, 0, 1, 16'h0010, 16'h0, 1, 1, 0, 16'h0020, 16'h1234);
      checkOutput($sformatf("lock.hold%0d.gnt1", c), 32'(gnt1A), 32'd0);
    end
    applyStimulus(1, 0, 0, 16'h0011, 16'h0, 1, 1, 0, 16'h0020, 16'h1234);
    checkOutput("lock.last.gnt0", 32'(gnt0A), 32'd1);
    checkOutput("lock.last.gnt1", 32'(gnt1A), 32'd0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0, 1, 1, 0, 16'h0020, 16'h1234);
    checkOutput("lock.after.gnt1",      32'(gnt1A),     32'd1);
    checkOutput("lock.after.mem_we",    32'(memWeA),    32'd1);
    checkOutput("lock.after.mem_addr",  32'(memAddrA),  32'h0020);
    checkOutput("lock.after.mem_wdata", 32'(memWdataA), 32'h1234);
    idle();

    // Lock released with no final access: port 1 waits one more cycle.
    applyStimulus(1, 0, 1, 16'h0012, 16'h0, 0, 0, 0, 16'h0000, 16'h0);
    checkOutput("rel.gnt0", 32'(gnt0A), 32'd1);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0, 1, 0, 0, 16'h0002, 16'h0);
    checkOutput("rel.drop.gnt1", 32'(gnt1A), 32'd0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0, 1, 0, 0, 16'h0002, 16'h0);
    checkOutput("rel.free.gnt1", 32'(gnt1A), 32'd1);
    idle();

    // A write from port 1 never produces a read return.
    applyStimulus(0, 0, 0, 16'h0000, 16'h0, 1, 1, 0, 16'h0030, 16'h5555);
    checkOutput("wr.gnt1",   32'(gnt1A),  32'd1);
    checkOutput("wr.mem_we", 32'(memWeA), 32'd1);
    for (int c = 0; c < 4; c++) begin
      idle();
      checkOutput($sformatf("wr.after%0d.rvalid1", c), 32'(rvalid1A), 32'd0);
    end

    // READ_LAT=3: alternating reads return in order with no gaps.
    for (int k = 0; k < 6; k++) begin
      case (k)
        0:       applyStimulus(1, 0, 0, 16'h0001, 16'h0, 0, 0, 0, 16'h0000, 16'h0);
        1:       applyStimulus(0, 0, 0, 16'h0000, 16'h0, 1, 0, 0, 16'h0002, 16'h0);
        2:       applyStimulus(1, 0, 0, 16'h0003, 16'h0, 0, 0, 0, 16'h0000, 16'h0);
        default: idle();
      endcase
      checkOutput($sformatf("lat3.c%0d.rvalid0", k), 32'(rvalid0C), 32'(k == 3 || k == 5));
      checkOutput($sformatf("lat3.c%0d.rvalid1", k), 32'(rvalid1C), 32'(k == 4));
      if (k == 3) checkOutput("lat3.c3.rdata0", 32'(rdata0C), 32'h1001);
      if (k == 4) checkOutput("lat3.c4.rdata1", 32'(rdata1C), 32'h1002);
      if (k == 5) checkOutput("lat3.c5.rdata0", 32'(rdata0C), 32'h1003);
    end

    // READ_LAT=2: reset right after a locked read drops the grant, the
    // in-flight tag and the lock.
    applyStimulus(1, 0, 1, 16'h0010, 16'h0, 0, 0, 0, 16'h0000, 16'h0);
    checkOutput("mid.gnt0", 32'(gnt0B), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid.rst.gnt0",   32'(gnt0B),  32'd0);
    checkOutput("mid.rst.mem_en", 32'(memEnB), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req0 = 0; lock0 = 0; addr0 = '0;
    req1 = 1; we1 = 0; addr1 = 16'h0002;
    #1;
    checkOutput("mid.free.gnt1",   32'(gnt1B),    32'd1);
    checkOutput("mid.rel.rvalid0", 32'(rvalid0B), 32'd0);
    for (int c = 0; c < 3; c++) begin
      idle();
      checkOutput($sformatf("mid.after%0d.rvalid0", c), 32'(rvalid0B), 32'd0);
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/punc_mem_arbiter.md
Name: punc_mem_arbiter

Overview:
Shares PUnC's single-port data memory between two requesters. Port 0 is the CPU datapath, driven by the control FSM's DMem_rd/DMem_wr. Port 1 is the debug/program-loader port. The block arbitrates per cycle, supports a lock for back-to-back accesses (the LDI/STI indirect pair), prevents starvation of the non-priority port and tags read returns back to their issuer.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
READ_LAT, 1, memory read latency in cycles (1..4)
PRIO_PORT, 0, port that wins simultaneous requests (0 or 1)
MAX_WAIT, 8, cycles the low-priority port may be refused before a forced grant (1..255)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
req0  in  1  port 0 access request
we0  in  1  port 0 write enable (0 = read)
lock0  in  1  port 0 keeps ownership after its current access
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 access issued this cycle
rvalid0  out  1  port 0 read data valid
rdata0  out  DATA_W  port 0 read data
req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid READ_LAT cycles after a read strobe

Behaviour:
- Reset (rst=0, asynchronous): owner=NONE, wait counter=0, read-tag pipeline cleared. Outputs gnt0/1=0, rvalid0/1=0, mem_en=0, mem_we=0. rdata0/1 track mem_rdata, but are meaningful only while rvalid is 1.
- FSM owner states:
  - FREE: no lock is held.
  - OWN0: port 0 holds a lock.
  - OWN1: port 1 holds a lock.
- FREE selection, combinational within the cycle:
  - If only one port requests, that port is granted.
  - If both request, PRIO_PORT is granted, unless the wait counter equals MAX_WAIT; then the other port is granted.
- OWNn: only port n can be granted. The other port's req is ignored (refused), even when the counter is saturated.
- gntN=1 means the access is issued that cycle. mem_en=1; mem_we, mem_addr and mem_wdata are muxed from port N. With no grant, mem_en=0, mem_we=0, and mem_addr/mem_wdata=0.
- Requester must hold req/we/addr/wdata stable until it sees gnt. One access per grant per cycle; a port may be granted on consecutive cycles.
- Lock transitions, evaluated at the clock edge:
  - Granted with lockN=1 → OWNn.
  - In OWNn, lockN=0 with no reqN → FREE. The other port can be granted the following cycle.
  - In OWNn, a final access with reqN=1 and lockN=0 is granted, then → FREE.
- Wait counter:
  - Increments, saturating at MAX_WAIT, each cycle the non-PRIO_PORT port requests and is not granted.
  - Clears to 0 when that port is granted, or when it drops its request.
  - Never clears because PRIO_PORT was granted.
- Read return: a granted read pushes the issuing port's tag into a READ_LAT-deep shift register. rvalidN=1 exactly READ_LAT cycles after the read grant, for one cycle.
  - Writes push no tag; rvalid never asserts for writes.
  - Back-to-back reads from alternating ports return in issue order with no bubbles.
- Simultaneous events: a grant and an rvalid to the same or a different port in the same cycle are legal and independent.
- Reset asserted mid-operation discards in-flight read tags; no rvalid follows reset deassertion.

Test Plan:
- Reset, then req0=1 read addr 0x0010 (memory holds 0xBEEF) → gnt0=1 same cycle, mem_en=1, mem_addr=0x0010. Next cycle (READ_LAT=1) rvalid0=1, rdata0=0xBEEF; rvalid1=0.
- Both ports request reads every cycle, PRIO_PORT=0, MAX_WAIT=8 → gnt0 for 8 cycles. In the 9th cycle gnt1=1 (forced) and the counter clears. The pattern then repeats with period 9.
- Port 0 read with lock0=1, port 1 write (addr 0x0020, wdata 0x1234) pending:
  - Port 0's read is granted; port 1 is refused while lock0 stays high, including after the counter saturates.
  - Port 0's second access with lock0=0 is granted.
  - gnt1 asserts the next cycle with mem_we=1, mem_addr=0x0020, mem_wdata=0x1234.
- READ_LAT=3, alternating reads port 0 @0x1, port 1 @0x2, port 0 @0x3 on consecutive cycles → rvalid0, rvalid1, rvalid0 on cycles 3, 4, 5 with the matching data.
- Port 1 write only → gnt1=1, mem_we=1, and rvalid1 stays 0 for 4 subsequent cycles.
- Assert rst low one cycle after a read grant with READ_LAT=2 → gnt/mem_en drop immediately, no rvalid afterwards, and the owner returns to FREE.
